// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : 8-bit UART receiver, mid-bit sampling, ready/valid byte output
//           with frame, parity and overrun flags. Parity checking is built
//           only when UART_RX_PARITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_DIV_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    input  logic [CLK_DIV_WIDTH-1:0] clk_div_i,
    input  logic                     parity_en_i,
    input  logic                     parity_odd_i,
    input  logic                     rx_i,
    output logic [7:0]               data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     frame_err_o,
    output logic                     parity_err_o,
    output logic                     overrun_o
);

    localparam logic [CLK_DIV_WIDTH-1:0] c_MIN_DIV = CLK_DIV_WIDTH'(4);
    localparam logic [CLK_DIV_WIDTH-1:0] c_ONE     = CLK_DIV_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_rx_prev;
    logic [CLK_DIV_WIDTH-1:0] r_div;
    logic [CLK_DIV_WIDTH-1:0] r_cnt;
    logic [2:0]               r_bit;
    logic [7:0]               r_shift;
    logic                     r_par_err;
    logic [7:0]               r_data;
    logic                     r_valid;
    logic                     r_ferr;
    logic                     r_perr;
    logic                     r_ovr;

    logic                     w_rx;
    logic                     w_fall;
    logic                     w_par_en;
    logic                     w_par_calc;
    logic [CLK_DIV_WIDTH-1:0] w_target;
    logic                     w_tick;
    logic                     w_start;
    logic                     w_shift;
    logic                     w_par_smp;
    logic                     w_stop_smp;
    logic                     w_load;

`ifdef UART_RX_PARITY_EN
    assign w_par_en   = parity_en_i;
    assign w_par_calc = ((^r_shift) ^ w_rx) != parity_odd_i;
`else
    logic w_unused_par;
    assign w_unused_par = parity_en_i ^ parity_odd_i;
    assign w_par_en     = 1'b0;
    assign w_par_calc   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx   = r_sync2;
    assign w_fall = r_rx_prev & ~w_rx;

    // START waits half a bit so every later sample lands mid-bit.
    assign w_target = (r_state == S_START) ? (r_div >> 1) : r_div;
    assign w_tick   = (r_cnt == (w_target - c_ONE));

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_par_smp   = 1'b0;
        w_stop_smp  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = w_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = w_par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_par_smp   = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_stop_smp  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_div     <= c_MIN_DIV;
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_par_err <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
            // Divisor is frozen for the whole frame once the start edge is seen.
            if (w_start) begin
                r_div     <= (clk_div_i < c_MIN_DIV) ? c_MIN_DIV : clk_div_i;
                r_bit     <= 3'd0;
                r_par_err <= 1'b0;
            end else begin
                if (w_shift) begin
                    r_bit   <= r_bit + 3'd1;
                    r_shift <= {w_rx, r_shift[7:1]};
                end
                if (w_par_smp) begin
                    r_par_err <= w_par_calc;
                end
            end
        end
    end

    // A finished frame is dropped only while an unaccepted byte is held.
    assign w_load = w_stop_smp & (~r_valid | ready_i);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= w_stop_smp & r_valid & ~ready_i;
            if (w_load) begin
                r_data  <= r_shift;
                r_ferr  <= ~w_rx;
                r_perr  <= r_par_err;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o       = r_data;
    assign valid_o      = r_valid;
    assign frame_err_o  = r_ferr;
    assign parity_err_o = r_perr;
    assign overrun_o    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Self-checking bench for uart_rx; randomized frames vs. a
//           byte-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } res_t;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic [15:0] clk_div_i = 16'd16;
    logic        parity_en_i = 1'b0;
    logic        parity_odd_i = 1'b0;
    logic        rx_i = 1'b1;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        frame_err_o;
    logic        parity_err_o;
    logic        overrun_o;

    int   checks = 0;
    int   errors = 0;
    int   ovr_cycles = 0;
    res_t got_q[$];
    res_t exp_q[$];

    uart_rx #(.CLK_DIV_WIDTH(16)) dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .clk_div_i    (clk_div_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Records every accepted byte and every overrun cycle.
    always @(negedge clk_i) begin
        if (arst_ni) begin
            if (valid_o && ready_i) got_q.push_back({data_o, frame_err_o, parity_err_o});
            if (overrun_o) ovr_cycles++;
        end
    end

    function automatic res_t model(input logic [7:0] b, input logic stop,
                                   input logic pen, input logic podd, input logic pbit);
        res_t r;
        r.data = b;
        r.fe   = ~stop;
        r.pe   = 1'b0;
`ifdef UART_RX_PARITY_EN
        if (pen) r.pe = ((^b) ^ pbit) != podd;
`else
        if (pen & podd & pbit) r.pe = 1'b0;
`endif
        return r;
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rx_i = v;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int div, input logic stop,
                              input logic pen, input logic podd, input logic pbit,
                              input int gap);
        int per;
        per = (div < 4) ? 4 : div;
        clk_div_i    = 16'(div);
        parity_en_i  = pen;
        parity_odd_i = podd;
        drive_bit(1'b0, per);
        clk_div_i = 16'($urandom);
        for (int i = 0; i < 8; i++) drive_bit(b[i], per);
`ifdef UART_RX_PARITY_EN
        if (pen) drive_bit(pbit, per);
`endif
        drive_bit(stop, per);
        if (gap > 0) drive_bit(1'b1, gap);
    endtask

    task automatic test_reset;
        arst_ni = 1'b0;
        rx_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %02h exp 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err_o); end
        checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", parity_err_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun_o); end
        @(posedge clk_i); #1;
        arst_ni = 1'b1;
        drive_bit(1'b1, 8);
    endtask

    task automatic test_basic;
        got_q.delete(); exp_q.delete();
        ready_i = 1'b1;
        send_frame(8'hA5, 16, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        exp_q.push_back(model(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (6) @(posedge clk_i); #1;
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_frame got %02h/%b/%b exp %02h/%b/%b", got_q[i].data, got_q[i].fe,
                         got_q[i].pe, exp_q[i].data, exp_q[i].fe, exp_q[i].pe);
            end
        end
    endtask

    task automatic test_glitch;
        got_q.delete(); exp_q.delete();
        clk_div_i = 16'd16;
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 40);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL glitch_count got %0d exp 0", got_q.size()); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b exp 0", valid_o); end
        send_frame(8'h96, 16, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        repeat (6) @(posedge clk_i); #1;
        checks++;
        if (got_q.size() !== 1 || got_q[0].data !== 8'h96) begin
            errors++;
            $display("FAIL glitch_next got count %0d data %02h exp 1 x 96", got_q.size(),
                     (got_q.size() > 0) ? got_q[0].data : 8'hxx);
        end
    endtask

    task automatic test_frame_err;
        got_q.delete(); exp_q.delete();
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        drive_bit(1'b0, 48);
        drive_bit(1'b1, 16);
        send_frame(8'h5A, 16, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        exp_q.push_back(model(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(model(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (6) @(posedge clk_i); #1;
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL ferr_count got %0d exp 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ferr_frame[%0d] got %02h/%b/%b exp %02h/%b/%b", i, got_q[i].data, got_q[i].fe,
                         got_q[i].pe, exp_q[i].data, exp_q[i].fe, exp_q[i].pe);
            end
        end
    endtask

    task automatic test_parity;
        got_q.delete(); exp_q.delete();
        send_frame(8'h07, 16, 1'b1, 1'b1, 1'b0, 1'b0, 8);
        exp_q.push_back(model(8'h07, 1'b1, 1'b1, 1'b0, 1'b0));
        send_frame(8'h07, 16, 1'b1, 1'b1, 1'b0, 1'b1, 8);
        exp_q.push_back(model(8'h07, 1'b1, 1'b1, 1'b0, 1'b1));
        send_frame(8'hC1, 12, 1'b1, 1'b1, 1'b1, 1'b0, 8);
        exp_q.push_back(model(8'hC1, 1'b1, 1'b1, 1'b1, 1'b0));
        parity_en_i = 1'b0;
        repeat (6) @(posedge clk_i); #1;
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL parity_count got %0d exp 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL parity_frame[%0d] got %02h/%b/%b exp %02h/%b/%b", i, got_q[i].data, got_q[i].fe,
                         got_q[i].pe, exp_q[i].data, exp_q[i].fe, exp_q[i].pe);
            end
        end
    endtask

    task automatic test_overrun;
        got_q.delete(); exp_q.delete();
        ovr_cycles = 0;
        ready_i = 1'b0;
        send_frame(8'h11, 16, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        send_frame(8'h22, 16, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        repeat (6) @(posedge clk_i); #1;
        checks++; if (data_o !== 8'h11) begin errors++; $display("FAIL ovr_data got %02h exp 11", data_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid_held got %b exp 1", valid_o); end
        checks++; if (ovr_cycles !== 1) begin errors++; $display("FAIL ovr_pulse got %0d cycles exp 1", ovr_cycles); end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear got %b exp 0", valid_o); end
        checks++;
        if (got_q.size() !== 1 || got_q[0].data !== 8'h11) begin
            errors++;
            $display("FAIL ovr_accept got count %0d exp 1 byte 11", got_q.size());
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_midframe;
        got_q.delete(); exp_q.delete();
        ready_i = 1'b0;
        send_frame(8'h81, 16, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        clk_div_i = 16'd16;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 4 * 16 + 8);
        #2;
        arst_ni = 1'b0;
        #1;
        checks++;
        if (data_o !== 8'h00 || valid_o !== 1'b0 || frame_err_o !== 1'b0 ||
            parity_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got %02h/%b/%b/%b/%b exp 00/0/0/0/0", data_o, valid_o,
                     frame_err_o, parity_err_o, overrun_o);
        end
        repeat (3) @(posedge clk_i); #1;
        arst_ni = 1'b1;
        ready_i = 1'b1;
        drive_bit(1'b1, 6 * 16);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL midreset_novalid got %0d exp 0", got_q.size()); end
        send_frame(8'h5A, 16, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        repeat (6) @(posedge clk_i); #1;
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== model(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL midreset_next got count %0d exp 1 byte 5a", got_q.size());
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic       stop, pen, podd, pbit;
        int         div, gap;
        got_q.delete(); exp_q.delete();
        ready_i = 1'b1;
        for (int f = 0; f < 25; f++) begin
            b    = 8'($urandom);
            div  = $urandom_range(1, 24);
            stop = ($urandom_range(0, 4) != 0);
            pen  = 1'($urandom);
            podd = 1'($urandom);
            pbit = 1'($urandom);
            gap  = $urandom_range(stop ? 0 : 1, 5);
            send_frame(b, div, stop, pen, podd, pbit, gap);
            exp_q.push_back(model(b, stop, pen, podd, pbit));
        end
        drive_bit(1'b1, 8);
        repeat (6) @(posedge clk_i); #1;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_frame[%0d] got %02h/%b/%b exp %02h/%b/%b", i, got_q[i].data, got_q[i].fe,
                         got_q[i].pe, exp_q[i].data, exp_q[i].fe, exp_q[i].pe);
            end
        end
    endtask

    initial begin
        @(posedge clk_i); #1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_parity();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_DIV_WIDTH, default 16, width of the bit-period divisor input.
REQ-002 clk_i  input  1  rising-edge clock.
REQ-003 arst_ni  input  1  asynchronous active-low reset.
REQ-004 clk_div_i  input  CLK_DIV_WIDTH  clk_i cycles per bit, N.
REQ-005 parity_en_i  input  1  parity bit expected after data when 1 (macro builds only).
REQ-006 parity_odd_i  input  1  1 = odd parity, 0 = even (macro builds only).
REQ-007 rx_i  input  1  asynchronous serial line, idle high.
REQ-008 data_o  output  8  received byte, LSB first on line.
REQ-009 valid_o  output  1  data_o, frame_err_o and parity_err_o are valid.
REQ-010 ready_i  input  1  consumer accepts data when valid_o && ready_i.
REQ-011 frame_err_o  output  1  stop bit sampled low for the held byte.
REQ-012 parity_err_o  output  1  parity mismatch for the held byte.
REQ-013 overrun_o  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-014 rx_i SHALL pass through a 2-flop synchroniser, reset value 1; all logic uses the synchronised rx, adding 2 cycles of input latency.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE->START SHALL occur on a synchronised 1->0 transition; N is latched here (values <4 clamped to 4), and later clk_div_i changes are ignored until the next frame.
REQ-017 START SHALL wait floor(N/2) cycles and then sample: 0 -> DATA; 1 -> IDLE, with no outputs changed (glitch rejection).
REQ-018 DATA SHALL sample 8 bits, one every N cycles, shifting them LSB first; after bit 7 it SHALL go to PARITY if parity is enabled, else to STOP.
REQ-019 PARITY SHALL sample one bit after N cycles; the error is (XOR of 8 data bits ^ parity bit) != parity_odd_i.
REQ-020 STOP SHALL sample after N cycles and then return to IDLE; a sample of 0 sets the frame error.
REQ-021 A low stop sample SHALL NOT itself start a frame; a new 1->0 edge is required.
REQ-022 The cycle after the stop sample, with valid_o low or valid_o && ready_i, data_o, frame_err_o and parity_err_o SHALL load and valid_o SHALL be 1.
REQ-023 The cycle after the stop sample, with valid_o high and ready_i low, the new frame SHALL be discarded, the held byte and flags unchanged, and overrun_o 1 for one cycle.
REQ-024 valid_o SHALL stay high, with data and flags stable, until accepted; it SHALL clear the cycle after valid_o && ready_i unless a new byte loads that same cycle.
REQ-025 A frame with an error SHALL still be delivered, with its flags.

Reset
REQ-026 With arst_ni low, at once: state IDLE, synchroniser 1, data_o 0x00, valid_o 0, frame_err_o 0, parity_err_o 0, overrun_o 0, counters 0.
REQ-027 Reset mid-frame SHALL abort the frame; after release the FSM waits in IDLE for a new 1->0 edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state, parity_en_i, parity_odd_i and parity_err_o logic SHALL be present.
REQ-029 Macro undefined: the ports SHALL still exist, the inputs ignored, PARITY never entered, and parity_err_o tied 0.

Verification
REQ-030 N=16, ready_i=1, frame 0xA5 with stop=1 -> data_o=0xA5, valid_o high 1 cycle after the stop sample, both error flags 0.
REQ-031 N=16, rx_i low 5 cycles then high -> FSM back in IDLE, valid_o stays 0.
REQ-032 N=16, frame 0x3C with stop=0 -> data_o=0x3C, frame_err_o=1; a second frame is received only after rx_i returns high then falls.
REQ-033 Macro defined, parity_en_i=1, parity_odd_i=0, frame 0x07 with parity bit 0 -> parity_err_o=1; same byte with parity bit 1 -> 0.
REQ-034 ready_i=0, frames 0x11 then 0x22 -> data_o stays 0x11, overrun_o one pulse; ready_i=1 -> valid_o clears next cycle.
REQ-035 arst_ni low during data bit 4 of 0xFF -> all outputs at reset values, no valid_o; next frame 0x5A received correctly.
